// File: rtl/c1_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : c1_bus_if
// Brief    : Shared A1/D1/C1 wires between the CPU (master) and the cache-side
//            responder (slave). Each side exposes a value and an enable.
// Revision : 1.0 - initial release
// ============================================================================
interface c1_bus_if #(
    parameter int ADDR1_W = 15,
    parameter int DATA_W  = 16,
    parameter int CTR_W   = 3
);
    logic [ADDR1_W-1:0] a1;

    logic [DATA_W-1:0]  m_d1;
    logic               m_d1_oe;
    logic [CTR_W-1:0]   m_c1;
    logic               m_c1_oe;

    logic [DATA_W-1:0]  s_d1;
    logic               s_d1_oe;
    logic [CTR_W-1:0]   s_c1;
    logic               s_c1_oe;

    wire  [DATA_W-1:0]  d1;
    wire  [CTR_W-1:0]   c1;

    // Resolved wire: whichever side enables drives it, otherwise it floats.
    assign d1 = s_d1_oe ? s_d1 : (m_d1_oe ? m_d1 : {DATA_W{1'bz}});
    assign c1 = s_c1_oe ? s_c1 : (m_c1_oe ? m_c1 : {CTR_W{1'bz}});

    modport master (output a1, m_d1, m_d1_oe, m_c1, m_c1_oe, input d1, c1);
    modport slave  (input a1, d1, c1, output s_d1, s_d1_oe, s_c1, s_c1_oe);
endinterface
`default_nettype wire

// File: rtl/c1_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : c1_bus_responder
// Brief    : Cache-side C1 bus endpoint: decodes a two-beat command, issues
//            one core request, returns RESPONSE and read beats.
//            Optional feature macro: C1_ALIGN_CHECK_EN (misaligned-access trap).
// Revision : 1.0 - initial release
// ============================================================================
module c1_bus_responder #(
    parameter int ADDR1_W  = 15,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 16,
    parameter int CTR_W    = 3
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    c1_bus_if.slave                           bus,
    output logic                              core_valid_o,
    output logic [CTR_W-1:0]                  core_cmd_o,
    output logic [ADDR1_W+OFFSET_W-1:0]       core_addr_o,
    output logic [2*DATA_W-1:0]               core_wdata_o,
    input  wire logic                         core_done_i,
    input  wire logic [2*DATA_W-1:0]          core_rdata_i,
    output logic                              err_o
);
    localparam logic [CTR_W-1:0] c_cmd_nop     = CTR_W'(0);
    localparam logic [CTR_W-1:0] c_cmd_read8   = CTR_W'(1);
    localparam logic [CTR_W-1:0] c_cmd_read16  = CTR_W'(2);
    localparam logic [CTR_W-1:0] c_cmd_read32  = CTR_W'(3);
    localparam logic [CTR_W-1:0] c_cmd_write8  = CTR_W'(5);
    localparam logic [CTR_W-1:0] c_cmd_write16 = CTR_W'(6);
    localparam logic [CTR_W-1:0] c_cmd_write32 = CTR_W'(7);
    localparam logic [CTR_W-1:0] c_cmd_resp    = CTR_W'(7);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr2 = 3'd1;
    localparam logic [2:0] c_st_req   = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_resp  = 3'd4;

    logic [2:0]            state_q,   state_d;
    logic [CTR_W-1:0]      cmd_q,     cmd_d;
    logic [ADDR1_W-1:0]    addr_hi_q, addr_hi_d;
    logic [OFFSET_W-1:0]   off_q,     off_d;
    logic [2*DATA_W-1:0]   wdata_q,   wdata_d;
    logic [2*DATA_W-1:0]   rdata_q,   rdata_d;
    logic [1:0]            beat_q,    beat_d;
    logic                  mis_q,     mis_d;
    logic                  core_valid_q, core_valid_d;
    logic                  c1_oe_q,   c1_oe_d;
    logic [CTR_W-1:0]      c1_q,      c1_d;
    logic                  d1_oe_q,   d1_oe_d;
    logic [DATA_W-1:0]     d1_q,      d1_d;
    logic                  err_q,     err_d;

    logic                  w_cmd_seen;
    logic                  w_is_read;
    logic [1:0]            w_nbeats;
    logic [DATA_W-1:0]     w_beat0;
    logic                  w_misaligned;

    // x/z or NOP on C1 never matches the range, so they read as idle.
    assign w_cmd_seen = bus.c1 inside {[CTR_W'(1):CTR_W'(7)]};
    assign w_is_read  = cmd_q inside {c_cmd_read8, c_cmd_read16, c_cmd_read32};
    assign w_nbeats   = (cmd_q == c_cmd_read32) ? 2'd2 : 2'd1;

    always_comb begin
        w_beat0 = '0;
        case (bus.c1)
            c_cmd_write8:                 w_beat0 = {{(DATA_W-8){1'b0}}, bus.d1[7:0]};
            c_cmd_write16, c_cmd_write32: w_beat0 = bus.d1;
            default:                      w_beat0 = '0;
        endcase
    end

`ifdef C1_ALIGN_CHECK_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (cmd_q)
            c_cmd_read16, c_cmd_write16: w_misaligned = bus.a1[0];
            c_cmd_read32, c_cmd_write32: w_misaligned = |bus.a1[1:0];
            default:                     w_misaligned = 1'b0;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_idle;
            cmd_q        <= '0;
            addr_hi_q    <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            beat_q       <= '0;
            mis_q        <= 1'b0;
            core_valid_q <= 1'b0;
            c1_oe_q      <= 1'b0;
            c1_q         <= c_cmd_nop;
            d1_oe_q      <= 1'b0;
            d1_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_hi_q    <= addr_hi_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            beat_q       <= beat_d;
            mis_q        <= mis_d;
            core_valid_q <= core_valid_d;
            c1_oe_q      <= c1_oe_d;
            c1_q         <= c1_d;
            d1_oe_q      <= d1_oe_d;
            d1_q         <= d1_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_hi_d = addr_hi_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        beat_d    = beat_q;
        mis_d     = mis_q;
        case (state_q)
            c_st_idle: begin
                if (w_cmd_seen) begin
                    state_d   = c_st_addr2;
                    cmd_d     = bus.c1;
                    addr_hi_d = bus.a1;
                    off_d     = '0;
                    wdata_d   = {{DATA_W{1'b0}}, w_beat0};
                    rdata_d   = '0;
                    beat_d    = '0;
                    mis_d     = 1'b0;
                end
            end
            c_st_addr2: begin
                off_d = bus.a1[OFFSET_W-1:0];
                wdata_d[2*DATA_W-1:DATA_W] = (cmd_q == c_cmd_write32) ? bus.d1 : '0;
                mis_d   = w_misaligned;
                state_d = w_misaligned ? c_st_resp : c_st_req;
            end
            c_st_req:  state_d = c_st_wait;
            c_st_wait: begin
                if (core_done_i) begin
                    rdata_d = core_rdata_i;
                    state_d = c_st_resp;
                end
            end
            c_st_resp: begin
                if (beat_q == w_nbeats) begin
                    state_d = c_st_idle;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Drivers are registered from the current state, so they trail it by one edge.
    always_comb begin
        core_valid_d = 1'b0;
        c1_oe_d      = 1'b0;
        c1_d         = c_cmd_nop;
        d1_oe_d      = 1'b0;
        d1_d         = '0;
        err_d        = 1'b0;
        case (state_q)
            c_st_req: begin
                core_valid_d = 1'b1;
                c1_oe_d      = 1'b1;
            end
            c_st_wait: begin
                core_valid_d = ~core_done_i;
                c1_oe_d      = 1'b1;
            end
            c_st_resp: begin
                if (beat_q != w_nbeats) begin
                    c1_oe_d = 1'b1;
                    c1_d    = c_cmd_resp;
                    err_d   = mis_q;
                    if (w_is_read) begin
                        d1_oe_d = 1'b1;
                        case (cmd_q)
                            c_cmd_read8:  d1_d = {{(DATA_W-8){1'b0}}, rdata_q[7:0]};
                            c_cmd_read16: d1_d = rdata_q[DATA_W-1:0];
                            default:      d1_d = beat_q[0] ? rdata_q[2*DATA_W-1:DATA_W]
                                                           : rdata_q[DATA_W-1:0];
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.s_c1    = c1_q;
    assign bus.s_c1_oe = c1_oe_q;
    assign bus.s_d1    = d1_q;
    assign bus.s_d1_oe = d1_oe_q;

    assign core_valid_o = core_valid_q;
    assign core_cmd_o   = cmd_q;
    assign core_addr_o  = {addr_hi_q, off_q};
    assign core_wdata_o = wdata_q;
    assign err_o        = err_q;
endmodule
`default_nettype wire
